// File: rtl/period_filter_pkg.sv
// Shared types and arithmetic for the multi-channel period filter.
// Optional filter seeding on channel start: PERIOD_FILTER_SEED_EN.
package period_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALF = 2'd1,
    ST_RUN  = 2'd2
  } ch_state_t;

  localparam int PF_MAXW = 64;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // y + ((x - y) >>> k); callers zero-extend and truncate to their width
  function automatic logic [PF_MAXW-1:0] kpow2_step(
    input logic [PF_MAXW-1:0] y,
    input logic [PF_MAXW-1:0] x,
    input int unsigned        k
  );
    logic signed [PF_MAXW:0] d;
    d = ($signed({1'b0, x}) - $signed({1'b0, y})) >>> k;
    return PF_MAXW'({1'b0, y} + d);
  endfunction

endpackage

// File: rtl/period_filter_mc_tracker.sv
// Per-channel half-period pairing, liveness FSM and no-edge timeout.
// Optional filter seeding on channel start: PERIOD_FILTER_SEED_EN.
module period_channel_tracker
  import period_filter_pkg::*;
#(
  parameter int DURATION_BITS = 15,
  parameter int TIMEOUT_BITS  = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     i_valid,
  input  logic [DURATION_BITS-1:0] i_duration,
  output logic                     o_run,
  output logic [DURATION_BITS:0]   o_period,
  output logic [DURATION_BITS:0]   o_sum,
  output logic                     o_unf_valid,
  output logic                     o_timeout,
  output logic                     o_seed
);

  localparam logic [TIMEOUT_BITS-1:0] TO_MAX = '1;

  ch_state_t                r_state;
  ch_state_t                w_state_nxt;
  logic [DURATION_BITS-1:0] r_prev;
  logic [DURATION_BITS:0]   r_period;
  logic [DURATION_BITS:0]   w_sum;
  logic [TIMEOUT_BITS-1:0]  r_cnt;
  logic [TIMEOUT_BITS-1:0]  w_cnt_nxt;
  logic                     r_unf_valid;
  logic                     w_upd;

  always_comb begin
    w_sum       = {1'b0, r_prev} + {1'b0, i_duration};
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    if (i_valid) begin
      w_cnt_nxt = '0;
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_HALF;
        default: begin
          w_state_nxt = ST_RUN;
          w_upd       = 1'b1;
        end
      endcase
    end else begin
      if (r_cnt != TO_MAX)
        w_cnt_nxt = r_cnt + TIMEOUT_BITS'(1);
      // an edge in the saturating cycle keeps the channel alive
      if (w_cnt_nxt == TO_MAX)
        w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_prev      <= '0;
      r_period    <= '0;
      r_cnt       <= '0;
      r_unf_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_unf_valid <= w_upd;
      if (i_valid)
        r_prev <= i_duration;
      if (w_upd)
        r_period <= w_sum;
    end
  end

  assign o_run       = (r_state == ST_RUN);
  assign o_period    = r_period;
  assign o_sum       = w_sum;
  assign o_unf_valid = r_unf_valid;
  assign o_timeout   = (r_cnt == TO_MAX);
  assign o_seed      = i_valid && (r_state == ST_HALF);

endmodule

// File: rtl/period_filter_mc.sv
// Multi-channel period pairing and cascaded k=2^-K IIR smoothing.
// Optional filter seeding on channel start: PERIOD_FILTER_SEED_EN.
module period_filter_mc
  import period_filter_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int DURATION_BITS  = 15,
  parameter int INTERNAL_BITS  = 32,
  parameter int OUTPUT_BITS    = 32,
  parameter int FILTER_STAGES  = 4,
  parameter int FILTER_K_SHIFT = 6,
  parameter int TIMEOUT_BITS   = 16
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [CHANNELS-1:0]                 IN_VALID,
  input  logic [CHANNELS*DURATION_BITS-1:0]   IN_DURATION,
  output logic [CHANNELS-1:0]                 UNFILTERED_VALID,
  output logic [CHANNELS*(DURATION_BITS+1)-1:0] UNFILTERED_DURATION,
  output logic                                OUT_VALID,
  output logic [idx_width(CHANNELS)-1:0]      OUT_CHANNEL,
  output logic [OUTPUT_BITS-1:0]              OUT_DURATION,
  output logic [CHANNELS-1:0]                 TIMEOUT
);

  localparam int CW    = idx_width(CHANNELS);
  localparam int SW    = idx_width(FILTER_STAGES);
  localparam int ALIGN = INTERNAL_BITS - DURATION_BITS - 1;
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(FILTER_STAGES - 1);
`ifdef PERIOD_FILTER_SEED_EN
  localparam bit SEED_EN = 1'b1;
`else
  localparam bit SEED_EN = 1'b0;
`endif

  logic [CHANNELS-1:0]      w_run;
  logic [CHANNELS-1:0]      w_seed;
  logic [INTERNAL_BITS-1:0] w_per_al  [CHANNELS];
  logic [INTERNAL_BITS-1:0] w_seed_al [CHANNELS];
  logic [INTERNAL_BITS-1:0] r_y [CHANNELS][FILTER_STAGES];
  logic [CW-1:0]            r_ch;
  logic [SW-1:0]            r_st;
  logic [INTERNAL_BITS-1:0] w_x;
  logic [INTERNAL_BITS-1:0] w_y;
  logic [INTERNAL_BITS-1:0] w_step;
  logic                     w_act;
  logic                     w_last;
  logic                     r_out_valid;
  logic [CW-1:0]            r_out_ch;
  logic [OUTPUT_BITS-1:0]   r_out_dur;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DURATION_BITS:0] w_period;
    logic [DURATION_BITS:0] w_sum;

    period_channel_tracker #(
      .DURATION_BITS(DURATION_BITS),
      .TIMEOUT_BITS (TIMEOUT_BITS)
    ) u_trk (
      .CLK        (CLK),
      .RESET      (RESET),
      .i_valid    (IN_VALID[c]),
      .i_duration (IN_DURATION[c*DURATION_BITS +: DURATION_BITS]),
      .o_run      (w_run[c]),
      .o_period   (w_period),
      .o_sum      (w_sum),
      .o_unf_valid(UNFILTERED_VALID[c]),
      .o_timeout  (TIMEOUT[c]),
      .o_seed     (w_seed[c])
    );

    assign UNFILTERED_DURATION[c*(DURATION_BITS+1) +: DURATION_BITS+1]
      = w_period;
    assign w_per_al[c]  = INTERNAL_BITS'(w_period) << ALIGN;
    assign w_seed_al[c] = INTERNAL_BITS'(w_sum) << ALIGN;
  end

  // stage 0 reads the period, later stages the stage just updated
  always_comb begin
    w_act  = w_run[r_ch];
    w_last = (r_st == ST_LAST);
    w_y    = r_y[r_ch][r_st];
    w_x    = (r_st == '0) ? w_per_al[r_ch]
                          : r_y[r_ch][r_st - SW'(1)];
    w_step = INTERNAL_BITS'(kpow2_step(PF_MAXW'(w_y), PF_MAXW'(w_x),
                                       FILTER_K_SHIFT));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ch <= '0;
      r_st <= '0;
    end else if (w_last) begin
      r_st <= '0;
      r_ch <= (r_ch == CH_LAST) ? '0 : r_ch + CW'(1);
    end else begin
      r_st <= r_st + SW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int s = 0; s < FILTER_STAGES; s++)
          r_y[c][s] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        for (int s = 0; s < FILTER_STAGES; s++)
          if (SEED_EN && w_seed[c])
            r_y[c][s] <= w_seed_al[c];
          else if (w_act && r_ch == CW'(c) && r_st == SW'(s))
            r_y[c][s] <= w_step;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_dur   <= '0;
    end else begin
      r_out_valid <= w_act && w_last;
      if (w_act && w_last) begin
        r_out_ch  <= r_ch;
        r_out_dur <= w_step[INTERNAL_BITS-1 -: OUTPUT_BITS];
      end
    end
  end

  assign OUT_VALID    = r_out_valid;
  assign OUT_CHANNEL  = r_out_ch;
  assign OUT_DURATION = r_out_dur;

endmodule

// File: tb/tb_period_filter_mc.sv
// Self-checking bench for period_filter_mc (TIMEOUT_BITS=8).
// Seeded-filter expectations apply when PERIOD_FILTER_SEED_EN is defined.
module tb_period_filter_mc;

  localparam int DB = 15;
  localparam int KS = 6;
  localparam logic [31:0] TARGET = 32'h07D0_0000;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  IN_VALID = '0;
  logic [29:0] IN_DURATION = '0;
  logic [1:0]  UNFILTERED_VALID;
  logic [31:0] UNFILTERED_DURATION;
  logic        OUT_VALID;
  logic [0:0]  OUT_CHANNEL;
  logic [31:0] OUT_DURATION;
  logic [1:0]  TIMEOUT;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  uv_q[$];
  logic [31:0] ud_q[$];

  period_filter_mc #(
    .CHANNELS      (2),
    .DURATION_BITS (15),
    .INTERNAL_BITS (32),
    .OUTPUT_BITS   (32),
    .FILTER_STAGES (4),
    .FILTER_K_SHIFT(6),
    .TIMEOUT_BITS  (8)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .IN_VALID           (IN_VALID),
    .IN_DURATION        (IN_DURATION),
    .UNFILTERED_VALID   (UNFILTERED_VALID),
    .UNFILTERED_DURATION(UNFILTERED_DURATION),
    .OUT_VALID          (OUT_VALID),
    .OUT_CHANNEL        (OUT_CHANNEL),
    .OUT_DURATION       (OUT_DURATION),
    .TIMEOUT            (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // flat sweep position (channel*4 + stage) expected after each edge
  always @(posedge CLK)
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic send(input logic [1:0] v, input int d0, input int d1,
                      input logic [1:0] ev, input int e0, input int e1);
    logic [1:0]  gv;
    logic [15:0] g0;
    logic [15:0] g1;
    uv_q.push_back(ev);
    ud_q.push_back({16'(e1), 16'(e0)});
    IN_VALID    = v;
    IN_DURATION = {DB'(d1), DB'(d0)};
    @(posedge CLK); #1;
    IN_VALID = '0;
    @(negedge CLK);
    gv = uv_q.pop_front();
    {g1, g0} = ud_q.pop_front();
    checks++;
    if (UNFILTERED_VALID !== gv) begin
      errors++;
      $display("FAIL unf_valid got %b want %b", UNFILTERED_VALID, gv);
    end
    if (gv[0]) begin
      checks++;
      if (UNFILTERED_DURATION[15:0] !== g0) begin
        errors++;
        $display("FAIL unf_dur0 got %0d want %0d",
                 UNFILTERED_DURATION[15:0], g0);
      end
    end
    if (gv[1]) begin
      checks++;
      if (UNFILTERED_DURATION[31:16] !== g1) begin
        errors++;
        $display("FAIL unf_dur1 got %0d want %0d",
                 UNFILTERED_DURATION[31:16], g1);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    int nov = 0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (OUT_VALID) nov++;
      if (i == 0) begin
        checks++;
        if ({UNFILTERED_VALID, UNFILTERED_DURATION, OUT_VALID,
             OUT_CHANNEL, OUT_DURATION, TIMEOUT} !== '0) begin
          errors++;
          $display("FAIL reset_outs got %h/%h/%b/%h/%b want 0",
                   UNFILTERED_DURATION, OUT_DURATION, OUT_VALID,
                   UNFILTERED_VALID, TIMEOUT);
        end
      end
      if (i == 254) begin
        checks++;
        if (TIMEOUT !== 2'b00) begin
          errors++;
          $display("FAIL timeout_254 got %b want 00", TIMEOUT);
        end
      end
      if (i == 255) begin
        checks++;
        if (TIMEOUT !== 2'b11) begin
          errors++;
          $display("FAIL timeout_255 got %b want 11", TIMEOUT);
        end
      end
    end
    checks++;
    if (nov != 0) begin
      errors++;
      $display("FAIL idle_out_valid got %0d pulses want 0", nov);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_filter();
    logic [31:0] ym [4];
    logic [31:0] xin;
    logic [31:0] got;
    logic [31:0] want;
    longint      d;
    longint      e;
    int          last_n = -1;
    for (int s = 0; s < 4; s++) begin
`ifdef PERIOD_FILTER_SEED_EN
      ym[s] = TARGET;
`else
      ym[s] = '0;
`endif
    end
    for (int k = 0; k < 2000; k++) begin
      xin = TARGET;
      for (int s = 0; s < 4; s++) begin
        d     = longint'(xin) - longint'(ym[s]);
        ym[s] = ym[s] + 32'(d >>> KS);
        xin   = ym[s];
      end
      exp_q.push_back(ym[3]);
    end
    send(2'b01, 1000, 0, 2'b00, 0, 0);
    while (cyc % 8 != 7) begin
      @(posedge CLK); #1;
    end
    send(2'b01, 1000, 0, 2'b01, 2000, 0);
    got = '0;
    for (int n = 0; n < 17000 && exp_q.size() > 0; n++) begin
      IN_VALID    = (n % 200 == 199) ? 2'b01 : 2'b00;
      IN_DURATION = {DB'(0), DB'(1000)};
      @(negedge CLK);
      if (UNFILTERED_VALID[0]) begin
        checks++;
        if (UNFILTERED_DURATION[15:0] !== 16'd2000) begin
          errors++;
          $display("FAIL run_unf0 got %0d want 2000",
                   UNFILTERED_DURATION[15:0]);
        end
      end
      if (OUT_VALID) begin
        want = exp_q.pop_front();
        checks++;
        if (OUT_CHANNEL !== 1'b0 || OUT_DURATION !== want) begin
          errors++;
          $display("FAIL filt_out ch %0d got %h want ch 0 %h",
                   OUT_CHANNEL, OUT_DURATION, want);
        end
        if (last_n >= 0) begin
          checks++;
          if (n - last_n != 8) begin
            errors++;
            $display("FAIL out_spacing got %0d want 8", n - last_n);
          end
        end
        last_n = n;
        got    = OUT_DURATION;
      end
      @(posedge CLK); #1;
    end
    IN_VALID = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL filt_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    e = longint'(TARGET) - longint'(got);
    if (e < 0) e = -e;
    checks++;
    if (e * 100 > longint'(TARGET)) begin
      errors++;
      $display("FAIL filt_converge got %h want %h within 1%%", got, TARGET);
    end
  endtask

  task automatic test_timeout();
    int          nov = 0;
    logic [31:0] held = '0;
    send(2'b01, 1000, 0, 2'b01, 2000, 0);
    for (int i = 1; i <= 320; i++) begin
      @(negedge CLK);
      if (i == 254) begin
        checks++;
        if (TIMEOUT[0] !== 1'b0) begin
          errors++;
          $display("FAIL run_to_254 got %b want 0", TIMEOUT[0]);
        end
      end
      if (i == 255) begin
        checks++;
        if (TIMEOUT !== 2'b11) begin
          errors++;
          $display("FAIL run_to_255 got %b want 11", TIMEOUT);
        end
      end
      if (i == 256) held = OUT_DURATION;
      if (i >= 256 && OUT_VALID) nov++;
    end
    checks++;
    if (nov != 0) begin
      errors++;
      $display("FAIL to_out_valid got %0d pulses want 0", nov);
    end
    checks++;
    if (OUT_DURATION !== held) begin
      errors++;
      $display("FAIL to_frozen got %h want %h", OUT_DURATION, held);
    end
    @(posedge CLK); #1;
    send(2'b01, 1000, 0, 2'b00, 0, 0);
    checks++;
    if (TIMEOUT[0] !== 1'b0) begin
      errors++;
      $display("FAIL revive_to got %b want 0", TIMEOUT[0]);
    end
    send(2'b01, 500, 0, 2'b01, 1500, 0);
  endtask

  task automatic test_back_to_back();
    int n0 = 0;
    int n1 = 0;
    send(2'b11, 32767, 32767, 2'b01, 33267, 0);
    send(2'b11, 32767, 32767, 2'b11, 65534, 65534);
    repeat (253) begin
      @(posedge CLK); #1;
    end
    checks++;
    if (TIMEOUT !== 2'b00) begin
      errors++;
      $display("FAIL pre_sat_to got %b want 00", TIMEOUT);
    end
    send(2'b11, 32767, 32767, 2'b11, 65534, 65534);
    checks++;
    if (TIMEOUT !== 2'b00) begin
      errors++;
      $display("FAIL sat_edge_to got %b want 00", TIMEOUT);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (OUT_VALID && OUT_CHANNEL == 1'b0) n0++;
      if (OUT_VALID && OUT_CHANNEL == 1'b1) n1++;
    end
    checks++;
    if (n0 != 2 || n1 != 2) begin
      errors++;
      $display("FAIL both_run_outs got %0d/%0d want 2/2", n0, n1);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    int nov = 0;
    while (cyc % 8 != 6) begin
      @(posedge CLK); #1;
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({UNFILTERED_VALID, UNFILTERED_DURATION, OUT_VALID,
         OUT_CHANNEL, OUT_DURATION, TIMEOUT} !== '0) begin
      errors++;
      $display("FAIL mid_reset got %h/%h/%b want 0",
               UNFILTERED_DURATION, OUT_DURATION, OUT_VALID);
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      if (OUT_VALID) nov++;
    end
    checks++;
    if (nov != 0) begin
      errors++;
      $display("FAIL mid_reset_out got %0d pulses want 0", nov);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_seed();
`ifdef PERIOD_FILTER_SEED_EN
    int seen = 0;
    send(2'b01, 1000, 0, 2'b00, 0, 0);
    send(2'b01, 1000, 0, 2'b01, 2000, 0);
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge CLK);
      if (OUT_VALID) begin
        seen = 1;
        checks++;
        if (OUT_CHANNEL !== 1'b0 || OUT_DURATION !== TARGET) begin
          errors++;
          $display("FAIL seed_out got ch %0d %h want ch 0 %h",
                   OUT_CHANNEL, OUT_DURATION, TARGET);
        end
      end
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL seed_wait got none want one OUT_VALID");
    end
    @(posedge CLK); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_filter();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_seed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
